qspi_psram_emu: RTL and testbench

Synthesizable, oversampled QSPI PSRAM emulator for FPGA bring-up and simulation of the uLinux SoC. It is the parametrised successor to the behavioural PSRAM model on the SoC's PSRAM chip-select. It samples the SPI pins with the system clock, decodes SPI and QPI command sets, and serves reads and writes from an internal memory of parametrised depth. It sits on the board side of the `uio` pins, opposite the SoC's memory controller.

---
 rtl/qspi_psram_emu.sv | 214 +++++++++++++++++++++
 tb/tb_qspi_psram_emu.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/qspi_psram_emu.sv
// qspi_psram_emu: oversampled QSPI/QPI PSRAM emulator.
// All pins are sampled on clk. sck edges are found after a 2-flop
// synchroniser and are only honoured while the synchronised ce_n is low.
module qspi_psram_emu #(
  parameter int    ADDR_W    = 16,
  parameter int    QUAD_WAIT = 6,
  parameter string INIT_FILE = ""
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce_n,
  input  logic       sck,
  input  logic [3:0] dio_in,
  output logic [3:0] dio_out,
  output logic [3:0] dio_oe,
  output logic       qpi_mode
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_WAIT, S_RDATA, S_WDATA, S_DONE, S_IGNORE
  } state_t;

  typedef enum logic [2:0] {
    OP_NONE, OP_ENTER, OP_EXIT, OP_RSTEN, OP_RST
  } op_t;

  localparam logic [7:0] QW = 8'(QUAD_WAIT);

  logic [1:0]      ce_s, sck_s;
  logic [1:0][3:0] dio_s;
  logic            ce_d, sck_d;
  logic            ce_hi, ce_rise, rise, fall;
  logic [3:0]      din;

  state_t      state, nxt;
  op_t         op, d_op;
  logic [7:0]  cnt, lim, wait_n, d_wait;
  logic [23:0] sr, sr_nxt;
  logic        cur_q, last, qa, qd, is_wr, qpi, rst_en;
  logic        d_qa, d_qd, d_wr;
  state_t      d_st;
  logic [7:0]  obuf, pbuf, wr_data, rd_byte;
  logic        wr_pend;
  logic [ADDR_W-1:0] addr, rd_a;
  logic [7:0]  mem [0:(1<<ADDR_W)-1];
  logic        unused_bits;

  assign ce_hi    = ce_s[1];
  assign ce_rise  = ce_s[1] & ~ce_d;
  assign rise     = ~ce_hi & sck_s[1] & ~sck_d;
  assign fall     = ~ce_hi & ~sck_s[1] & sck_d;
  assign din      = dio_s[1];
  assign qpi_mode = qpi;
  assign unused_bits = sr[23];

  // Pin synchronisers plus one-deep history for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_s  <= 2'b11;
      sck_s <= '0;
      dio_s <= '0;
      ce_d  <= 1'b1;
      sck_d <= 1'b0;
    end else begin
      ce_s  <= {ce_s[0], ce_n};
      sck_s <= {sck_s[0], sck};
      dio_s <= {dio_s[0], dio_in};
      ce_d  <= ce_s[1];
      sck_d <= sck_s[1];
    end
  end

  // Phase width and length for the current state
  always_comb begin
    cur_q = qd;
    lim   = qd ? 8'd1 : 8'd7;
    case (state)
      S_CMD:   begin cur_q = qpi; lim = qpi ? 8'd1 : 8'd7;  end
      S_ADDR:  begin cur_q = qa;  lim = qa  ? 8'd5 : 8'd23; end
      S_WAIT:  lim = wait_n - 8'd1;
      default: ;
    endcase
    sr_nxt = cur_q ? {sr[19:0], din} : {sr[22:0], din[0]};
    last   = (cnt == lim);
    rd_a   = (state == S_ADDR) ? sr_nxt[ADDR_W-1:0] : addr;
  end

  assign rd_byte = mem[rd_a];

  // Command decode of the byte completing on this rising edge
  always_comb begin
    d_st   = S_IGNORE;
    d_wr   = 1'b0;
    d_qa   = qpi;
    d_qd   = qpi;
    d_wait = 8'd0;
    d_op   = OP_NONE;
    case (sr_nxt[7:0])
      8'h03: d_st = S_ADDR;
      8'h0B: begin d_st = S_ADDR; d_wait = qpi ? QW : 8'd8; end
      8'hEB: begin d_st = S_ADDR; d_qa = 1'b1; d_qd = 1'b1; d_wait = QW; end
      8'h02: begin d_st = S_ADDR; d_wr = 1'b1; end
      8'h38: begin d_st = S_ADDR; d_wr = 1'b1; d_qa = 1'b1; d_qd = 1'b1; end
      8'h35: if (!qpi) begin d_st = S_DONE; d_op = OP_ENTER; end
      8'hF5: if (qpi)  begin d_st = S_DONE; d_op = OP_EXIT;  end
      8'h66: begin d_st = S_DONE; d_op = OP_RSTEN; end
      8'h99: begin d_st = S_DONE; d_op = OP_RST;   end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  // Next-state logic; a deselect always returns to IDLE
  always_comb begin
    nxt = state;
    if (ce_hi) nxt = S_IDLE;
    else begin
      case (state)
        S_IDLE: nxt = S_CMD;
        S_CMD:  if (rise && last) nxt = d_st;
        S_ADDR: if (rise && last)
                  nxt = is_wr ? S_WDATA : ((wait_n != 8'd0) ? S_WAIT : S_RDATA);
        S_WAIT: if (rise && last) nxt = S_RDATA;
        // any clock past the 8 command bits voids a mode command
        S_DONE: if (rise) nxt = S_IGNORE;
        default: ;
      endcase
    end
  end

  // Datapath: shifting, addressing, read prefetch, mode flags, pin drive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0; sr <= '0; wait_n <= '0; op <= OP_NONE;
      qa <= 1'b0; qd <= 1'b0; is_wr <= 1'b0; qpi <= 1'b0; rst_en <= 1'b0;
      obuf <= '0; pbuf <= '0; wr_data <= '0; wr_pend <= 1'b0; addr <= '0;
      dio_out <= '0; dio_oe <= '0;
    end else begin
      wr_pend <= 1'b0;
      if (wr_pend) addr <= addr + 1'b1;
      if (ce_rise) begin
        rst_en <= 1'b0;
        if (state == S_DONE) begin
          case (op)
            OP_ENTER: qpi <= 1'b1;
            OP_EXIT:  qpi <= 1'b0;
            OP_RSTEN: rst_en <= 1'b1;
            OP_RST:   if (rst_en) qpi <= 1'b0;
            default:  ;
          endcase
        end
      end
      if (ce_hi) begin
        cnt     <= '0;
        dio_oe  <= '0;
        dio_out <= '0;
      end else if (rise && (state inside {S_CMD, S_ADDR, S_WAIT, S_WDATA})) begin
        cnt <= last ? 8'd0 : cnt + 8'd1;
        sr  <= sr_nxt;
        if (last) begin
          case (state)
            S_CMD: begin
              op <= d_op; is_wr <= d_wr; qa <= d_qa; qd <= d_qd; wait_n <= d_wait;
            end
            S_ADDR:
              if (!is_wr && wait_n == 8'd0) begin
                obuf <= rd_byte;
                addr <= sr_nxt[ADDR_W-1:0] + 1'b1;
              end else begin
                addr <= sr_nxt[ADDR_W-1:0];
              end
            S_WAIT: begin
              obuf <= rd_byte;
              addr <= addr + 1'b1;
            end
            // commit happens next clk so a partial byte never reaches memory
            S_WDATA: begin
              wr_pend <= 1'b1;
              wr_data <= sr_nxt[7:0];
            end
            default: ;
          endcase
        end
      end else if (fall && state == S_RDATA) begin
        cnt    <= last ? 8'd0 : cnt + 8'd1;
        dio_oe <= qd ? 4'hF : 4'h2;
        if (qd) begin
          dio_out <= obuf[7:4];
          obuf    <= {obuf[3:0], 4'h0};
        end else begin
          dio_out <= {2'b00, obuf[7], 1'b0};
          obuf    <= {obuf[6:0], 1'b0};
        end
        // fetch the following byte while this one shifts out
        if (cnt == 8'd0) begin
          pbuf <= rd_byte;
          addr <= addr + 1'b1;
        end
        if (last) obuf <= pbuf;
      end
    end
  end

  // Memory write port; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_pend) mem[addr] <= wr_data;
  end

endmodule

// File: tb/tb_qspi_psram_emu.sv
// Directed bench for qspi_psram_emu: host drives mode-0 SPI/QPI with an
// sck half-period of 5 clk and samples read data just before each rise.
module tb_qspi_psram_emu;
  localparam int HALF = 50;
  typedef logic [7:0] bq_t [$];

  logic       clk = 1'b0, rst_n = 1'b0, ce_n = 1'b1, sck = 1'b0;
  logic [3:0] dio_in = 4'h0;
  logic [3:0] dio_out, dio_oe;
  logic       qpi_mode;
  logic [3:0] oe_or, oe_and;
  logic [3:0] q0;
  int passed = 0, total = 0, nfail = 0;

  always #5 clk = ~clk;

  qspi_psram_emu #(.ADDR_W(16), .QUAD_WAIT(6), .INIT_FILE("")) dut (
    .clk(clk), .rst_n(rst_n), .ce_n(ce_n), .sck(sck),
    .dio_in(dio_in), .dio_out(dio_out), .dio_oe(dio_oe), .qpi_mode(qpi_mode)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic oe_clr();
    oe_or = 4'h0; oe_and = 4'hF;
  endtask

  // one sck period: drive, sample before rise, rise, fall
  task automatic cyc(input logic [3:0] d, output logic [3:0] q);
    dio_in = d;
    #HALF;
    q = dio_out;
    oe_or  = oe_or | dio_oe;
    oe_and = oe_and & dio_oe;
    sck = 1'b1;
    #HALF;
    sck = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit quad);
    logic [3:0] q;
    if (quad) begin
      cyc(b[7:4], q); cyc(b[3:0], q);
    end else
      for (int i = 7; i >= 0; i--) cyc({3'b000, b[i]}, q);
  endtask

  task automatic send_addr(input logic [23:0] a, input bit quad);
    send(a[23:16], quad); send(a[15:8], quad); send(a[7:0], quad);
  endtask

  task automatic recv(input bit quad, output logic [7:0] b);
    logic [3:0] q;
    b = 8'h00;
    if (quad) begin
      cyc(4'h0, q); b[7:4] = q;
      cyc(4'h0, q); b[3:0] = q;
    end else
      for (int i = 0; i < 8; i++) begin
        cyc(4'h0, q); b = {b[6:0], q[1]};
      end
  endtask

  task automatic sel();
    ce_n = 1'b0; #HALF;
  endtask

  task automatic desel();
    #HALF; ce_n = 1'b1; #200;
  endtask

  task automatic wr(input logic [7:0] cmd, input bit cq, input bit aq,
                    input logic [23:0] a, input bq_t d);
    sel();
    send(cmd, cq); send_addr(a, aq);
    foreach (d[i]) send(d[i], aq);
    desel();
  endtask

  task automatic rd(input logic [7:0] cmd, input bit cq, input bit aq,
                    input logic [23:0] a, input int waitn, input bq_t exp, input string tag);
    logic [7:0] b;
    logic [3:0] q;
    sel();
    oe_clr();
    send(cmd, cq); send_addr(a, aq);
    repeat (waitn) cyc(4'h0, q);
    chk({tag, " hdr oe"}, 32'(oe_or), 32'h0);
    oe_clr();
    foreach (exp[i]) begin
      recv(aq, b);
      chk($sformatf("%s byte%0d", tag, i), 32'(b), 32'(exp[i]));
    end
    chk({tag, " data oe"}, {oe_or, oe_and}, aq ? 32'hFF : 32'h22);
    #HALF; ce_n = 1'b1; #35;
    chk({tag, " oe off"}, 32'(dio_oe), 32'h0);
    #165;
  endtask

  task automatic cmd_only(input logic [7:0] cmd, input bit cq);
    sel(); send(cmd, cq); desel();
  endtask

  initial begin
    #23;
    chk("rst oe", 32'(dio_oe), 32'h0);
    chk("rst out", 32'(dio_out), 32'h0);
    chk("rst qpi", 32'(qpi_mode), 32'h0);
    rst_n = 1'b1;
    #50;

    // SPI write/read
    wr(8'h02, 1'b0, 1'b0, 24'h000010, '{8'hA5, 8'h5A});
    rd(8'h03, 1'b0, 1'b0, 24'h000010, 0, '{8'hA5, 8'h5A}, "spi rd");

    // quad write/read
    wr(8'h38, 1'b0, 1'b1, 24'h000020, '{8'h12, 8'h34, 8'h56});
    rd(8'hEB, 1'b0, 1'b1, 24'h000020, 6, '{8'h12, 8'h34, 8'h56}, "quad rd");
    rd(8'h0B, 1'b0, 1'b0, 24'h000010, 8, '{8'hA5}, "fast rd");

    // QPI entry, traffic, exit
    cmd_only(8'h35, 1'b0);
    chk("qpi on", 32'(qpi_mode), 32'h1);
    wr(8'h02, 1'b1, 1'b1, 24'h000100, '{8'hC3});
    rd(8'h0B, 1'b1, 1'b1, 24'h000100, 6, '{8'hC3}, "qpi rd");
    cmd_only(8'hF5, 1'b1);
    chk("qpi off", 32'(qpi_mode), 32'h0);
    cmd_only(8'h35, 1'b0);
    chk("qpi re-on", 32'(qpi_mode), 32'h1);
    cmd_only(8'hF5, 1'b1);
    chk("qpi re-off", 32'(qpi_mode), 32'h0);
    cmd_only(8'hF5, 1'b0);
    chk("spi f5 ign", 32'(qpi_mode), 32'h0);
    rd(8'h03, 1'b0, 1'b0, 24'h000100, 0, '{8'hC3}, "after f5");

    // reset command sequencing
    cmd_only(8'h35, 1'b0);
    chk("qpi on2", 32'(qpi_mode), 32'h1);
    cmd_only(8'h99, 1'b1);
    chk("99 alone", 32'(qpi_mode), 32'h1);
    cmd_only(8'h66, 1'b1);
    chk("66 only", 32'(qpi_mode), 32'h1);
    cmd_only(8'h99, 1'b1);
    chk("66 99", 32'(qpi_mode), 32'h0);

    // address wrap
    wr(8'h02, 1'b0, 1'b0, 24'h00FFFF, '{8'h77, 8'h88});
    rd(8'h03, 1'b0, 1'b0, 24'h00FFFF, 0, '{8'h77, 8'h88}, "wrap rd");
    rd(8'h03, 1'b0, 1'b0, 24'h000000, 0, '{8'h88}, "wrap0");

    // partial byte discarded at deselect
    sel();
    send(8'h02, 1'b0); send_addr(24'h000010, 1'b0); send(8'h3C, 1'b0);
    repeat (4) cyc(4'h1, q0);
    desel();
    rd(8'h03, 1'b0, 1'b0, 24'h000010, 0, '{8'h3C, 8'h5A}, "abort");

    // unknown command: no drive, no write
    sel();
    oe_clr();
    send(8'hAB, 1'b0); send_addr(24'h000010, 1'b0); send(8'h00, 1'b0);
    desel();
    chk("unk oe", 32'(oe_or), 32'h0);
    rd(8'h03, 1'b0, 1'b0, 24'h000010, 0, '{8'h3C}, "after unk");

    // reset in the middle of a QPI read
    cmd_only(8'h35, 1'b0);
    chk("qpi on3", 32'(qpi_mode), 32'h1);
    sel();
    send(8'h03, 1'b1); send_addr(24'h000020, 1'b1);
    cyc(4'h0, q0);
    chk("mid nib", 32'(q0), 32'h1);
    chk("mid oe", 32'(dio_oe), 32'hF);
    rst_n = 1'b0;
    #1;
    chk("arst oe", 32'(dio_oe), 32'h0);
    chk("arst out", 32'(dio_out), 32'h0);
    chk("arst qpi", 32'(qpi_mode), 32'h0);
    ce_n = 1'b1;
    #50;
    rst_n = 1'b1;
    #100;
    rd(8'h03, 1'b0, 1'b0, 24'h000020, 0, '{8'h12, 8'h34}, "post rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
